// File: rtl/booth_main.sv
// Sequential radix-2 Booth signed multiplier that performs one recoding step per clock.
// Defining BOOTH_FLAGS_EN adds the registered result flags product_zero and product_neg.
module booth_main #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
`ifdef BOOTH_FLAGS_EN
  ,
  output logic                 product_zero,
  output logic                 product_neg
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state, state_nx;
  logic [WIDTH:0]     m, a, a_sum, a_sh;
  logic [WIDTH-1:0]   q, q_sh;
  logic               q_m1;
  logic [CW-1:0]      count;
  logic               last;
  logic [2*WIDTH-1:0] result;

  assign busy = (state == CALC);
  assign last = (count == CW'(1));

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One Booth step: add or subtract M, then arithmetic-shift {A,Q,q_m1} right by one.
  always_comb begin
    a_sum = a;
    case ({q[0], q_m1})
      2'b01:   a_sum = a + m;
      2'b10:   a_sum = a - m;
      default: a_sum = a;
    endcase
    a_sh   = {a_sum[WIDTH], a_sum[WIDTH:1]};
    q_sh   = {a_sum[0], q[WIDTH-1:1]};
    result = {a_sh[WIDTH-1:0], q_sh};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m            <= '0;
      a            <= '0;
      q            <= '0;
      q_m1         <= 1'b0;
      count        <= '0;
      done         <= 1'b0;
      product      <= '0;
`ifdef BOOTH_FLAGS_EN
      product_zero <= 1'b0;
      product_neg  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // A is one bit wider than the operands so A-M with M = most-negative cannot overflow.
            m     <= {multiplicand[WIDTH-1], multiplicand};
            a     <= '0;
            q     <= multiplier;
            q_m1  <= 1'b0;
            count <= CW'(WIDTH);
          end
        end
        CALC: begin
          a     <= a_sh;
          q     <= q_sh;
          q_m1  <= q[0];
          count <= count - CW'(1);
          if (last) begin
            product      <= result;
            done         <= 1'b1;
`ifdef BOOTH_FLAGS_EN
            product_zero <= (result == '0);
            product_neg  <= result[2*WIDTH-1];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_main.sv
// Scoreboard bench for booth_main (WIDTH=4): directed, extreme, sweep, handshake and reset cases.
// Flag outputs are checked when BOOTH_FLAGS_EN is defined.
module tb_booth_main;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   multiplicand, multiplier;
  logic           busy, done;
  logic [2*W-1:0] product;
`ifdef BOOTH_FLAGS_EN
  logic           product_zero, product_neg;
`endif

  booth_main #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
`ifdef BOOTH_FLAGS_EN
    ,
    .product_zero (product_zero),
    .product_neg  (product_neg)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    int             acc;
  } exp_t;

  exp_t           sb[$];
  int             n_cmp = 0;
  int             n_err = 0;
  int             cycle = 0;
  int             prev_acc = 0;
  logic [2*W-1:0] last_p = '0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse; between pulses product must hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("reset_done", done, 0);
      check("reset_busy", busy, 0);
      check("reset_product", product, 0);
      sb.delete();
      last_p = '0;
    end else if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("product", product, e.p);
        check("latency", cycle - e.acc, W);
`ifdef BOOTH_FLAGS_EN
        check("product_zero", product_zero, e.p == '0);
        check("product_neg", product_neg, e.p[2*W-1]);
`endif
        last_p = e.p;
      end
    end else begin
      check("product_stable", product, last_p);
    end
  end

  // Issue one multiply; hold keeps start high afterwards, b2b checks the back-to-back spacing.
  task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2*W-1:0] e, input bit hold, input bit b2b);
    exp_t s;
    int   t;
    t = 0;
    @(negedge clk);
    while (busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_timeout", 1, 0);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    @(posedge clk);
    #1;
    s.p   = e;
    s.acc = cycle;
    sb.push_back(s);
    check("busy_after_accept", busy, 1);
    if (b2b) check("b2b_spacing", cycle - prev_acc, W + 1);
    prev_acc = cycle;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] x, y;
    int           p;
    int           t;
    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (4) begin
      @(negedge clk);
      start = ~start;
      multiplicand = 4'd7;
      multiplier   = 4'd7;
    end
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("post_reset_product", product, 0);
    check("post_reset_busy", busy, 0);
    check("post_reset_done", done, 0);

    // Directed products with hand-computed results.
    mul(4'd3,  4'd2,  8'h06, 0, 0);
    mul(4'hD,  4'd2,  8'hFA, 0, 0);
    mul(4'd4,  4'hD,  8'hF4, 0, 0);
    mul(4'd7,  4'd7,  8'h31, 0, 0);
    mul(4'hC,  4'hC,  8'h10, 0, 0);
    mul(4'd0,  4'h9,  8'h00, 0, 0);
    mul(4'h8,  4'h8,  8'h40, 0, 0);
    mul(4'h8,  4'd7,  8'hC8, 0, 0);
    mul(4'd7,  4'h8,  8'hC8, 0, 0);

    // start pulsed while busy with different operands must be ignored.
    mul(4'd5,  4'hD,  8'hF1, 0, 0);
    @(negedge clk);
    start = 1'b1; multiplicand = 4'd7; multiplier = 4'd7;
    @(negedge clk);
    start = 1'b0;

    // start held high: back-to-back results every W+1 cycles.
    mul(4'd2,  4'd3,  8'h06, 1, 0);
    mul(4'hF,  4'hF,  8'h01, 1, 1);
    mul(4'd6,  4'hE,  8'hF4, 1, 1);
    mul(4'd5,  4'd5,  8'h19, 0, 1);

    // Mid-operation reset: aborts with no done, product cleared at once.
    mul(4'd7,  4'd7,  8'h31, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_product", product, 0);
    check("midreset_done", done, 0);
    check("midreset_busy", busy, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    mul(4'd3,  4'd2,  8'h06, 0, 0);

    // Exhaustive sweep with start held high; expected from a signed reference product.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        x = i[W-1:0];
        y = j[W-1:0];
        p = int'($signed(x)) * int'($signed(y));
        mul(x, y, p[2*W-1:0], !(i == 15 && j == 15), !(i == 0 && j == 0));
      end
    end

    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
